hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Produces the stall and flush controls consumed by the IF stage, IF_ID register and ID_EX register: PCWrite, IF_IDWrite, IF_IDFlash, ID_EXFlash, plus a global PipeHold.
- Resolves three hazard classes:
  - load-use: multi-cycle stall with bubble insertion.
  - taken branch: flush.
  - data-memory wait: full freeze with timeout.
- Sits beside the datapath in PipeP and is driven by ID, EX and MEM stage status.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, maximum MEMWAIT cycles before abort (1..255).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs  in  REG_AW  source register 1 of the instruction in ID.
- id_rt  in  REG_AW  source register 2 of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- branch_taken  in  1  taken-branch/jump resolved in EX (PCSrc).
- mem_req  in  1  MEM stage issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_IDWrite  out  1  IF_ID register load enable.
- IF_IDFlash  out  1  clear IF_ID to NOP.
- ID_EXFlash  out  1  clear ID_EX to bubble.
- PipeHold  out  1  freeze ID_EX, EX_MEM and MEM_WB.
- mem_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, counters=0.
  - PCWrite=0, IF_IDWrite=0, IF_IDFlash=1, ID_EXFlash=1, PipeHold=0, mem_err=0.
- Load-use detect (combinational): lu = ex_memread && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- FSM states: RUN, LUSTALL, MEMWAIT. Outputs are Mealy, so there is zero added latency in the detecting cycle.
- Per-cycle priority: MEMWAIT condition > branch_taken > lu.
- RUN:
  - Default outputs: PCWrite=1, IF_IDWrite=1, flushes=0, PipeHold=0.
  - mem_req && !mem_ready: PCWrite=0, IF_IDWrite=0, PipeHold=1, no flush. Go to MEMWAIT, tcnt=1.
  - Else branch_taken: IF_IDFlash=1, ID_EXFlash=1, PCWrite=1. Stay in RUN. Any simultaneous lu is discarded because the dependent instruction is flushed.
  - Else lu: PCWrite=0, IF_IDWrite=0, ID_EXFlash=1. If LOAD_LAT>1, go to LUSTALL with scnt=LOAD_LAT-1; else stay in RUN.
- LUSTALL:
  - Outputs: PCWrite=0, IF_IDWrite=0, ID_EXFlash=1.
  - scnt decrements each cycle; at scnt==1 return to RUN.
  - branch_taken arriving here flushes as in RUN and returns to RUN immediately.
  - A mem-wait condition goes to MEMWAIT; the stall count is dropped, and lu is re-evaluated on return.
- MEMWAIT:
  - Outputs: PCWrite=0, IF_IDWrite=0, PipeHold=1, no flush. branch_taken is ignored, because EX is frozen and it will be re-presented.
  - mem_ready=1: next state RUN. Pipeline resumes on the following cycle.
  - tcnt==MEM_TIMEOUT without ready: mem_err=1 for one cycle, then RUN (access abandoned).
  - tcnt saturates and is cleared on exit.
- Counter widths: scnt 3 bits, tcnt 8 bits; neither wraps.
- Reset mid-stall or mid-wait returns to RUN immediately, with outputs as defined under Reset.
- mem_req && mem_ready in the same RUN cycle is not a wait: no stall.

Optional Feature:
- HAZARD_PERF_CNT_EN, when defined:
  - Adds outputs stall_cnt[31:0], flush_cnt[31:0] and wait_cnt[31:0], reset to 0.
  - stall_cnt +1 per cycle with ID_EXFlash due to lu or LUSTALL.
  - flush_cnt +1 per branch flush cycle.
  - wait_cnt +1 per cycle with PipeHold=1.
  - All three saturate at 0xFFFFFFFF.
- When not defined: these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. Load-use, LOAD_LAT=2: ex_memread=1, ex_rd=5, id_rs=5 -> PCWrite=0, IF_IDWrite=0, ID_EXFlash=1 for exactly 2 cycles, then PCWrite=1.
2. No hazard on r0: ex_memread=1, ex_rd=0, id_rs=0 -> no stall, PCWrite=1, all flushes 0.
3. Branch with simultaneous lu: branch_taken=1 and lu true in the same cycle -> IF_IDFlash=1, ID_EXFlash=1, PCWrite=1, no stall cycle following.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> PipeHold=1 and PCWrite=0 for 4 cycles; branch_taken pulsed mid-wait produces no flush.
5. Timeout, MEM_TIMEOUT=4: mem_ready held 0 -> mem_err=1 pulse on the 4th wait cycle, PipeHold=0 on the next cycle.
6. Async reset asserted in LUSTALL between clock edges -> outputs immediately take reset values; after release, the first cycle shows RUN defaults.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Generates the stall/flush controls for the IF stage, IF_ID and ID_EX
// registers, plus a global pipeline hold for data-memory waits.
// Hazard classes handled:
//   - load-use: multi-cycle bubble insertion.
//   - taken branch: flush of IF_ID and ID_EX.
//   - memory wait: full freeze with timeout.
// Per-cycle priority is memory wait, then branch, then load-use.
// Outputs are Mealy, so the detecting cycle already carries the control.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating
// stall/flush/wait event counters as extra outputs.
module hazard_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              IF_IDFlash,
  output logic              ID_EXFlash,
  output logic              PipeHold,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       wait_cnt,
`endif
  output logic              mem_err
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LUSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  // Stall counter reload: the detecting RUN cycle is the first bubble.
  localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [7:0] TO_LIMIT  = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_scnt;
  logic [2:0]  w_scnt_nxt;
  logic [7:0]  r_tcnt;
  logic [7:0]  w_tcnt_nxt;

  logic w_lu;
  logic w_memcond;
  logic w_pcwrite;
  logic w_ifidwrite;
  logic w_ifidflash;
  logic w_idexflash;
  logic w_pipehold;
  logic w_memerr;
  logic w_stall_evt;
  logic w_flush_evt;

  // A load in EX whose (non-zero) destination is read by the ID instruction.
  assign w_lu = ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // A memory access that does not complete this cycle forces a freeze.
  assign w_memcond = mem_req && !mem_ready;

  // State and counter registers; reset returns to RUN with counters cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_scnt  <= 3'd0;
      r_tcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Next-state, counter update and Mealy control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_tcnt_nxt  = r_tcnt;
    w_pcwrite   = 1'b1;
    w_ifidwrite = 1'b1;
    w_ifidflash = 1'b0;
    w_idexflash = 1'b0;
    w_pipehold  = 1'b0;
    w_memerr    = 1'b0;
    w_stall_evt = 1'b0;
    w_flush_evt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_memcond) begin
          w_pcwrite   = 1'b0;
          w_ifidwrite = 1'b0;
          w_pipehold  = 1'b1;
          w_state_nxt = ST_MEMWAIT;
          w_tcnt_nxt  = 8'd1;
        end else if (branch_taken) begin
          // The dependent instruction is flushed, so any load-use is moot.
          w_ifidflash = 1'b1;
          w_idexflash = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_lu) begin
          w_pcwrite   = 1'b0;
          w_ifidwrite = 1'b0;
          w_idexflash = 1'b1;
          w_stall_evt = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_nxt = ST_LUSTALL;
            w_scnt_nxt  = LU_RELOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LUSTALL: begin
        if (w_memcond) begin
          // Remaining bubbles are dropped; load-use is re-checked after the wait.
          w_pcwrite   = 1'b0;
          w_ifidwrite = 1'b0;
          w_pipehold  = 1'b1;
          w_state_nxt = ST_MEMWAIT;
          w_scnt_nxt  = 3'd0;
          w_tcnt_nxt  = 8'd1;
        end else if (branch_taken) begin
          w_ifidflash = 1'b1;
          w_idexflash = 1'b1;
          w_flush_evt = 1'b1;
          w_state_nxt = ST_RUN;
          w_scnt_nxt  = 3'd0;
        end else begin
          w_pcwrite   = 1'b0;
          w_ifidwrite = 1'b0;
          w_idexflash = 1'b1;
          w_stall_evt = 1'b1;
          if (r_scnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
            w_scnt_nxt  = 3'd0;
          end else begin
            w_scnt_nxt  = r_scnt - 3'd1;
          end
        end
      end
      ST_MEMWAIT: begin
        // EX is frozen, so a branch seen here is re-presented later.
        w_pcwrite   = 1'b0;
        w_ifidwrite = 1'b0;
        w_pipehold  = 1'b1;
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_tcnt_nxt  = 8'd0;
        end else if (r_tcnt >= TO_LIMIT) begin
          w_memerr    = 1'b1;
          w_state_nxt = ST_RUN;
          w_tcnt_nxt  = 8'd0;
        end else if (r_tcnt != 8'hFF) begin
          w_tcnt_nxt  = r_tcnt + 8'd1;
        end else begin
          w_tcnt_nxt  = r_tcnt;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_scnt_nxt  = 3'd0;
        w_tcnt_nxt  = 8'd0;
      end
    endcase
  end

  // While reset is asserted the outputs take their reset values at once.
  assign PCWrite    = rst ? w_pcwrite   : 1'b0;
  assign IF_IDWrite = rst ? w_ifidwrite : 1'b0;
  assign IF_IDFlash = rst ? w_ifidflash : 1'b1;
  assign ID_EXFlash = rst ? w_idexflash : 1'b1;
  assign PipeHold   = rst ? w_pipehold  : 1'b0;
  assign mem_err    = rst ? w_memerr    : 1'b0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_wait_cnt;

  // Saturating event counters for stall bubbles, branch flushes and holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
      r_wait_cnt  <= 32'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
      if (w_pipehold && (r_wait_cnt != 32'hFFFF_FFFF)) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_cnt;
`else
  // Event strobes only feed the optional counters.
  logic w_unused_evt;
  assign w_unused_evt = w_stall_evt ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized
// traffic. A reference model turns each cycle's inputs into the expected
// control vector, which a monitor process later compares with the DUT.
module tb_hazard_ctrl;
  localparam int LL = 2;
  localparam int TO = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready;
  logic          PCWrite, IF_IDWrite, IF_IDFlash, ID_EXFlash, PipeHold, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt, wait_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(LL), .MEM_TIMEOUT(TO), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .IF_IDWrite(IF_IDWrite), .IF_IDFlash(IF_IDFlash), .ID_EXFlash(ID_EXFlash),
    .PipeHold(PipeHold),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
    .mem_err(mem_err)
  );

  // Expected vector: {PCWrite, IF_IDWrite, IF_IDFlash, ID_EXFlash, PipeHold, mem_err}
  logic [5:0] exp_q[$];
  int         tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_cyc = 0;

  // Reference model state, phrased as "bubbles still owed" and "waiting for memory".
  int bubbles_owed = 0;
  bit waiting      = 1'b0;
  int wait_age     = 0;

  // Drive one cycle of inputs at the falling edge and enqueue the expected controls.
  task automatic cyc(input bit r, input bit mr, input int rd, input int rs,
                     input int rt, input bit urt, input bit br,
                     input bit req, input bit rdy);
    logic [5:0] e;
    bit lu;
    @(negedge clk);
    rst = r; ex_memread = mr; ex_rd = AW'(rd); id_rs = AW'(rs); id_rt = AW'(rt);
    id_uses_rt = urt; branch_taken = br; mem_req = req; mem_ready = rdy;
    lu = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
    if (!r) begin
      e = 6'b001100;
      bubbles_owed = 0; waiting = 1'b0; wait_age = 0;
    end else if (waiting) begin
      e = 6'b000010;
      if (rdy) begin
        waiting = 1'b0; wait_age = 0;
      end else if (wait_age == TO) begin
        e[0] = 1'b1; waiting = 1'b0; wait_age = 0;
      end else begin
        wait_age = wait_age + 1;
      end
    end else if (req && !rdy) begin
      e = 6'b000010;
      waiting = 1'b1; wait_age = 1; bubbles_owed = 0;
    end else if (br) begin
      e = 6'b111100;
      bubbles_owed = 0;
    end else if (bubbles_owed > 0) begin
      e = 6'b000100;
      bubbles_owed = bubbles_owed - 1;
    end else if (lu) begin
      e = 6'b000100;
      bubbles_owed = LL - 1;
    end else begin
      e = 6'b110000;
    end
    exp_q.push_back(e);
    tag_q.push_back(n_cyc);
    n_cyc++;
  endtask

  // Monitor: just after each falling edge, compare DUT controls with the oldest expectation.
  initial begin
    logic [5:0] got, e;
    int t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {PCWrite, IF_IDWrite, IF_IDFlash, ID_EXFlash, PipeHold, mem_err};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL ctrl cycle %0d: got {PCW,IFW,IFF,IDF,HOLD,ERR}=%b required %b",
                   t, got, e);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic, then drain and report.
  initial begin
    int guard;
    rst = 1'b0; ex_memread = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // Reset state.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load on r0 is never a hazard.
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs: two bubble cycles, then normal flow.
    cyc(1, 1, 5, 5, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 0, 0, 0, 0, 0);
    // Load-use on rt, only when rt is read.
    cyc(1, 1, 7, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 7, 1, 7, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Branch together with load-use: flush only, no stall afterwards.
    cyc(1, 1, 5, 5, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Memory wait of three cycles, branch pulsed mid-wait, then ready.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Request completing in the same cycle is not a wait.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    // Timeout: ready never arrives.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Memory wait arriving during a load-use stall drops the stall.
    cyc(1, 1, 3, 3, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 0, 0, 0, 1, 0);
    cyc(1, 1, 3, 3, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset asserted between edges while stalling.
    cyc(1, 1, 5, 5, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0));
    end

    // Drain: allow the monitor a bounded number of cycles to empty the queue.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #5;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
